uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  UART receiver with an on-chip receive FIFO; the far-end counterpart of the team's buffered UART transmitter.
//  Frame: 1 start (0), 8 data LSB-first, 1 even-parity bit (optional), 1 stop (1).
//  Oversamples i_Rx_Serial, checks parity/framing and pushes good bytes into a first-word-fall-through FIFO.
//  The host drains that FIFO with i_Rx_Read.
// PARAMETERS
//  CLKS_PER_BIT  87  i_Clock cycles per UART bit (>=4), e.g. 10 MHz / 115200
//  FIFO_DEPTH    8   receive FIFO entries, power of 2, >=2
// PORTS
//  i_Clock       in   1  single clock; all logic on posedge
//  i_Reset       in   1  asynchronous, active-low reset
//  i_Rx_Serial   in   1  serial line, asynchronous to i_Clock, idles high
//  i_Rx_Read     in   1  pop FIFO head this cycle; ignored when empty
//  o_Rx_Byte     out  8  FIFO head byte, valid while o_Rx_DV=1
//  o_Rx_DV       out  1  FIFO not empty
//  o_Rx_Full     out  1  FIFO holds FIFO_DEPTH bytes
//  o_Rx_Active   out  1  frame in progress (START..STOP)
//  o_Parity_Err  out  1  1-cycle pulse: parity mismatch, byte dropped
//  o_Frame_Err   out  1  1-cycle pulse: stop bit sampled 0, byte dropped
//  o_Overrun     out  1  1-cycle pulse: good byte arrived with FIFO full and no pop, byte dropped
// BEHAVIOUR
//  Reset (i_Reset=0, async): FSM->IDLE, FIFO empty, pointers 0, synchroniser flops=1, arm=0.
//   All outputs 0, o_Rx_Byte=8'h00. An in-flight frame is lost.
//  Input: 2-flop synchroniser; FSM uses the synced bit only.
//  IDLE: arm<=1 once synced line seen 1. If arm && line==0: ->START, clear counters.
//   arm blocks false starts after reset or break.
//  START: at count CLKS_PER_BIT/2-1 re-sample. 0: ->DATA, count=0. 1 (glitch): ->IDLE, no error.
//  DATA: sample every CLKS_PER_BIT cycles (mid-bit) into bit r_Bit_Index, LSB first.
//   Parity accumulates one XOR per sampled bit. After bit 7: ->PARITY, or ->STOP if parity is compiled out.
//  PARITY: mid-bit sample; err = xor(data)^sample (even parity); ->STOP.
//  STOP: mid-bit sample. Exactly one action, in priority order:
//   stop==0 -> o_Frame_Err;
//   else parity err -> o_Parity_Err;
//   else FIFO full && !i_Rx_Read -> o_Overrun;
//   else push.
//   Then ->CLEANUP. On frame error, arm<=0, so a break must end before the next start is accepted.
//  CLEANUP: 1 cycle, ->IDLE. Total frame latency: last stop-mid sample + 1 cycle to o_Rx_DV.
//  FIFO: FWFT; push visible on o_Rx_Byte/o_Rx_DV the cycle after the push.
//   Simultaneous push+pop when full: both occur, count unchanged, no overrun.
//   Simultaneous push+pop when empty: count becomes 1.
//   Pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
//  Clock counter width $clog2(CLKS_PER_BIT); never exceeds CLKS_PER_BIT-1.
//  o_Rx_Active=1 in START, DATA, PARITY and STOP only.
// CONFIGURATION
//  Macro UART_RX_PARITY_EN.
//   Defined: PARITY state present, 11-bit frame, o_Parity_Err functional.
//   Undefined: 10-bit frame (DATA->STOP), no parity logic, o_Parity_Err tied 0.
//  Must match the transmitter build.
// STRUCTURE
//  Package uart_pkg: FSM state encodings (s_IDLE, s_RX_START_BIT, s_RX_DATA_BITS, s_RX_PARITY_BIT, s_RX_STOP_BIT, s_CLEANUP),
//   UART_DATA_BITS=8, and the parity function.
//  Sub-module uart_rx_buffer: FWFT FIFO (WIDTH, DEPTH) with push/pop/full/empty.
//  Sync, FSM and error pulses live in the top.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4, UART_RX_PARITY_EN defined unless noted)
//  1 Send 8'hA5, parity 0, stop 1 -> o_Rx_DV=1, o_Rx_Byte=8'hA5, no error pulses; i_Rx_Read -> o_Rx_DV=0.
//  2 Send 8'h01 with parity 0 (wrong) -> o_Parity_Err pulses once, FIFO stays empty.
//    With the macro undefined, a 10-bit 8'h01 frame -> byte received.
//  3 Send 8'h3C with stop=0, hold line low 30 cycles, then release -> o_Frame_Err once;
//    next frame 8'h5A is received correctly.
//  4 Send 5 bytes 8'h10..8'h14 without reads -> o_Rx_Full after the 4th, o_Overrun on the 5th;
//    reads return 10,11,12,13.
//    Repeat with i_Rx_Read pulsed in the 5th frame's stop-sample cycle -> no overrun; 8'h14 is stored.
//  5 Low glitch of 1 bit-time/4 on an idle line -> no o_Rx_Active after START, nothing pushed.
//    Assert i_Reset mid-DATA of a frame, release while line high -> FIFO empty, outputs 0;
//    next 8'hC3 is received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   uart_rx_state_e : receiver FSM states
//   UART_DATA_BITS  : payload bits per frame
//   parity_accum    : one even-parity accumulation step
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        s_IDLE,
        s_RX_START_BIT,
        s_RX_DATA_BITS,
        s_RX_PARITY_BIT,
        s_RX_STOP_BIT,
        s_CLEANUP
    } uart_rx_state_e;

    // Folding every data bit and then the received parity bit through this
    // function yields 1 exactly when even parity is violated.
    function automatic logic parity_accum(input logic acc, input logic sample);
        return acc ^ sample;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Host-side bundle of the UART receiver.
//   i_Rx_Serial  : serial line (asynchronous, idles high)
//   i_Rx_Read    : pop FIFO head
//   o_Rx_Byte    : FIFO head byte, valid while o_Rx_DV
//   o_Rx_DV      : FIFO not empty
//   o_Rx_Full    : FIFO full
//   o_Rx_Active  : frame in progress
//   o_Parity_Err / o_Frame_Err / o_Overrun : 1-cycle drop pulses
// slave modport: the receiver; master modport: the host / line driver.
interface uart_rx_fifo_if;
    import uart_pkg::*;

    logic                      i_Rx_Serial;
    logic                      i_Rx_Read;
    logic [UART_DATA_BITS-1:0] o_Rx_Byte;
    logic                      o_Rx_DV;
    logic                      o_Rx_Full;
    logic                      o_Rx_Active;
    logic                      o_Parity_Err;
    logic                      o_Frame_Err;
    logic                      o_Overrun;

    modport slave (
        input  i_Rx_Serial, i_Rx_Read,
        output o_Rx_Byte, o_Rx_DV, o_Rx_Full, o_Rx_Active,
               o_Parity_Err, o_Frame_Err, o_Overrun
    );

    modport master (
        output i_Rx_Serial, i_Rx_Read,
        input  o_Rx_Byte, o_Rx_DV, o_Rx_Full, o_Rx_Active,
               o_Parity_Err, o_Frame_Err, o_Overrun
    );

endinterface

// File: rtl/uart_rx_buffer.sv
// First-word-fall-through FIFO for received bytes.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write; accepted when not full or when a pop happens the same cycle
//   pop        : remove head; ignored when empty
//   rdata      : head entry (0 while empty)
//   full/empty : occupancy flags
module uart_rx_buffer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with receive FIFO.
// Frame: start(0), 8 data LSB first, [even parity], stop(1).
// Build option: define UART_RX_PARITY_EN for the 11-bit frame with parity
// checking; otherwise 10-bit frame and o_Parity_Err is held 0.
//   i_Clock : clock
//   i_Reset : asynchronous active-low reset
//   rx      : uart_rx_fifo_if.slave (serial in, read strobe, head byte,
//             status flags and error pulses)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic           i_Clock,
    input  logic           i_Reset,
    uart_rx_fifo_if.slave  rx
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

    uart_rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      sync1_q, sync2_q;
    logic                      arm_q, arm_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                      par_acc_q, par_acc_d;
    logic                      par_bad_q, par_bad_d;
    logic                      parity_err_q, parity_err_d;
`endif
    logic                      rx_bit;
    logic                      push;
    logic                      fifo_full, fifo_empty;

    assign rx_bit = sync2_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        data_d      = data_q;
        arm_d       = arm_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        push        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_acc_d    = par_acc_q;
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            s_IDLE: begin
                // arm is only set by a high line, so a break that outlives
                // reset or a framing error is never taken as a start bit
                if (rx_bit) arm_d = 1'b1;
                if (arm_q && !rx_bit) begin
                    state_d = s_RX_START_BIT;
                    cnt_d   = '0;
                    idx_d   = '0;
`ifdef UART_RX_PARITY_EN
                    par_acc_d = 1'b0;
                    par_bad_d = 1'b0;
`endif
                end
            end
            s_RX_START_BIT: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = '0;
                    state_d = rx_bit ? s_IDLE : s_RX_DATA_BITS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            s_RX_DATA_BITS: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d         = '0;
                    data_d[idx_q] = rx_bit;
`ifdef UART_RX_PARITY_EN
                    par_acc_d = parity_accum(par_acc_q, rx_bit);
`endif
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = s_RX_PARITY_BIT;
`else
                        state_d = s_RX_STOP_BIT;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            s_RX_PARITY_BIT: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d     = '0;
                    par_bad_d = parity_accum(par_acc_q, rx_bit);
                    state_d   = s_RX_STOP_BIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            s_RX_STOP_BIT: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = s_CLEANUP;
                    // exactly one outcome per frame, highest priority first
                    if (!rx_bit) begin
                        frame_err_d = 1'b1;
                        arm_d       = 1'b0;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                    end
`endif
                    else if (fifo_full && !rx.i_Rx_Read) begin
                        overrun_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            s_CLEANUP: state_d = s_IDLE;
            default:   state_d = s_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q     <= s_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            arm_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            sync1_q     <= rx.i_Rx_Serial;
            sync2_q     <= sync1_q;
            arm_q       <= arm_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_acc_q    <= par_acc_d;
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    uart_rx_buffer #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_buffer (
        .clk   (i_Clock),
        .rst_n (i_Reset),
        .push  (push),
        .wdata (data_d),
        .pop   (rx.i_Rx_Read),
        .rdata (rx.o_Rx_Byte),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rx.o_Rx_DV     = !fifo_empty;
    assign rx.o_Rx_Full   = fifo_full;
    assign rx.o_Rx_Active = (state_q == s_RX_START_BIT) || (state_q == s_RX_DATA_BITS) ||
                            (state_q == s_RX_PARITY_BIT) || (state_q == s_RX_STOP_BIT);
    assign rx.o_Frame_Err = frame_err_q;
    assign rx.o_Overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign rx.o_Parity_Err = parity_err_q;
`else
    assign rx.o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS  = 11;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int NBITS  = 10;
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int STOP_J = NBITS - 1;
    // Frame starts on negedge 0: 2 sync cycles + 1 IDLE cycle, then half a bit in START,
    // then one full bit per later frame bit; this is the posedge taking the stop sample.
    localparam int STOP_EDGE  = 3 + CPB / 2 + CPB * STOP_J;
    localparam int ACTIVE_CYC = CPB / 2 + CPB * STOP_J;
    localparam int TAIL       = 3 * CPB;

    logic clk = 1'b0;
    logic rst_n;
    uart_rx_fifo_if rx_if ();

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_Clock (clk),
        .i_Reset (rst_n),
        .rx      (rx_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int perr_seen = 0, ferr_seen = 0, ovr_seen = 0, active_seen = 0;
    logic [7:0] model_q[$];
    logic dv_b, dv_a;

    always @(negedge clk) begin
        if (rx_if.o_Parity_Err === 1'b1) perr_seen++;
        if (rx_if.o_Frame_Err === 1'b1)  ferr_seen++;
        if (rx_if.o_Overrun === 1'b1)    ovr_seen++;
        if (rx_if.o_Rx_Active === 1'b1)  active_seen++;
    end

    // Reference model: outcome of one frame by the priority rules, queue updated.
    // 0 stored, 1 framing error, 2 parity error, 3 overrun.
    function automatic int model_frame(input logic [7:0] d, input bit par_bad, input bit stop_bit, input bit rd);
        bit was_full;
        was_full = (model_q.size() == DEPTH);
        if (rd && model_q.size() > 0) void'(model_q.pop_front());
        if (!stop_bit) return 1;
        if (PAR_EN && par_bad) return 2;
        if (was_full && !rd) return 3;
        model_q.push_back(d);
        return 0;
    endfunction

    task automatic send_frame(input logic [7:0] d, input bit par_bad, input bit stop_bit,
                              input bit read_at_stop, input int hold_low);
        logic [10:0] bits;
        bits    = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (PAR_EN) begin
            bits[9]  = (^d) ^ par_bad;
            bits[10] = stop_bit;
        end else begin
            bits[9] = stop_bit;
        end
        for (int cyc = 0; cyc < NBITS * CPB + hold_low + TAIL; cyc++) begin
            @(negedge clk);
            if (cyc == STOP_EDGE - 1) dv_b = rx_if.o_Rx_DV;
            if (cyc == STOP_EDGE)     dv_a = rx_if.o_Rx_DV;
            if (cyc < NBITS * CPB)                 rx_if.i_Rx_Serial = bits[cyc / CPB];
            else if (cyc < NBITS * CPB + hold_low) rx_if.i_Rx_Serial = 1'b0;
            else                                   rx_if.i_Rx_Serial = 1'b1;
            rx_if.i_Rx_Read = read_at_stop && (cyc == STOP_EDGE - 1);
        end
        rx_if.i_Rx_Read = 1'b0;
    endtask

    task automatic test_drain(input string tag);
        for (int i = 0; i < DEPTH + 1 && model_q.size() > 0; i++) begin
            @(negedge clk);
            checks++;
            if ({rx_if.o_Rx_DV, rx_if.o_Rx_Byte} !== {1'b1, model_q[0]})
                $display("FAIL %s_head: got dv=%b byte=%h want dv=1 byte=%h", tag, rx_if.o_Rx_DV, rx_if.o_Rx_Byte, model_q[0]);
            else passed++;
            rx_if.i_Rx_Read = 1'b1;
            @(negedge clk);
            rx_if.i_Rx_Read = 1'b0;
            void'(model_q.pop_front());
        end
        @(negedge clk);
        checks++;
        if (rx_if.o_Rx_DV !== 1'b0) $display("FAIL %s_empty: got dv=%b want 0", tag, rx_if.o_Rx_DV);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_if.i_Rx_Serial = 1'b1;
        rx_if.i_Rx_Read   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_if.o_Rx_DV, rx_if.o_Rx_Full, rx_if.o_Rx_Active, rx_if.o_Parity_Err, rx_if.o_Frame_Err,
             rx_if.o_Overrun, rx_if.o_Rx_Byte} !== 14'h0)
            $display("FAIL reset_outputs: got dv=%b full=%b act=%b pe=%b fe=%b ov=%b byte=%h want all 0",
                     rx_if.o_Rx_DV, rx_if.o_Rx_Full, rx_if.o_Rx_Active, rx_if.o_Parity_Err,
                     rx_if.o_Frame_Err, rx_if.o_Overrun, rx_if.o_Rx_Byte);
        else passed++;
        rst_n = 1'b1;
        model_q.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        int p0, f0, o0, a0, code;
        p0 = perr_seen; f0 = ferr_seen; o0 = ovr_seen; a0 = active_seen;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 0);
        code = model_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        checks++;
        if (dv_b !== 1'b0) $display("FAIL basic_dv_before_push: got %b want 0", dv_b); else passed++;
        checks++;
        if (dv_a !== 1'b1) $display("FAIL basic_dv_after_push: got %b want 1", dv_a); else passed++;
        checks++;
        if (rx_if.o_Rx_Byte !== 8'hA5) $display("FAIL basic_byte: got %h want a5", rx_if.o_Rx_Byte); else passed++;
        checks++;
        if ((perr_seen - p0) + (ferr_seen - f0) + (ovr_seen - o0) !== 0)
            $display("FAIL basic_no_err: got %0d pulses want 0 (code %0d)", (perr_seen - p0) + (ferr_seen - f0) + (ovr_seen - o0), code);
        else passed++;
        checks++;
        if (active_seen - a0 !== ACTIVE_CYC) $display("FAIL basic_active_len: got %0d want %0d", active_seen - a0, ACTIVE_CYC);
        else passed++;
        test_drain("basic");
    endtask

    task automatic test_parity();
        int p0, code;
        p0 = perr_seen;
`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 0);
        code = model_frame(8'h01, 1'b1, 1'b1, 1'b0);
        checks++;
        if (perr_seen - p0 !== 1) $display("FAIL parity_pulse: got %0d want 1 (code %0d)", perr_seen - p0, code); else passed++;
        checks++;
        if (rx_if.o_Rx_DV !== 1'b0) $display("FAIL parity_dropped: got dv=%b want 0", rx_if.o_Rx_DV); else passed++;
`else
        send_frame(8'h01, 1'b0, 1'b1, 1'b0, 0);
        code = model_frame(8'h01, 1'b0, 1'b1, 1'b0);
        checks++;
        if (perr_seen - p0 !== 0) $display("FAIL parity_none: got %0d pulses want 0 (code %0d)", perr_seen - p0, code); else passed++;
        test_drain("noparity");
`endif
    endtask

    task automatic test_frame_err();
        int p0, f0, o0, a0, code;
        p0 = perr_seen; f0 = ferr_seen; o0 = ovr_seen; a0 = active_seen;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 30);
        code = model_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ferr_seen - f0 !== 1) $display("FAIL frame_pulse: got %0d want 1 (code %0d)", ferr_seen - f0, code); else passed++;
        checks++;
        if ((perr_seen - p0) + (ovr_seen - o0) !== 0) $display("FAIL frame_other: got %0d want 0", (perr_seen - p0) + (ovr_seen - o0));
        else passed++;
        checks++;
        if (active_seen - a0 !== ACTIVE_CYC) $display("FAIL frame_break_ignored: active %0d want %0d", active_seen - a0, ACTIVE_CYC);
        else passed++;
        checks++;
        if (rx_if.o_Rx_DV !== 1'b0) $display("FAIL frame_dropped: got dv=%b want 0", rx_if.o_Rx_DV); else passed++;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 0);
        code = model_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        test_drain("frame_recover");
    endtask

    task automatic test_overrun();
        int o0, code;
        for (int k = 0; k < 5; k++) begin
            o0 = ovr_seen;
            send_frame(8'h10 + 8'(k), 1'b0, 1'b1, 1'b0, 0);
            code = model_frame(8'h10 + 8'(k), 1'b0, 1'b1, 1'b0);
            checks++;
            if (rx_if.o_Rx_Full !== (k >= 3)) $display("FAIL ovr_full_%0d: got %b want %b", k, rx_if.o_Rx_Full, k >= 3);
            else passed++;
            checks++;
            if (ovr_seen - o0 !== ((code == 3) ? 1 : 0)) $display("FAIL ovr_pulse_%0d: got %0d want %0d", k, ovr_seen - o0, (code == 3) ? 1 : 0);
            else passed++;
        end
        test_drain("ovr");
        for (int k = 0; k < 5; k++) begin
            o0 = ovr_seen;
            send_frame(8'h10 + 8'(k), 1'b0, 1'b1, k == 4, 0);
            code = model_frame(8'h10 + 8'(k), 1'b0, 1'b1, k == 4);
        end
        checks++;
        if (ovr_seen - o0 !== 0) $display("FAIL ovr_pop_at_stop: got %0d pulses want 0 (code %0d)", ovr_seen - o0, code); else passed++;
        checks++;
        if (rx_if.o_Rx_Full !== 1'b1) $display("FAIL ovr_pop_full: got %b want 1", rx_if.o_Rx_Full); else passed++;
        test_drain("ovr_pop");
    endtask

    task automatic test_glitch();
        int p0, f0, o0, a0;
        p0 = perr_seen; f0 = ferr_seen; o0 = ovr_seen; a0 = active_seen;
        @(negedge clk) rx_if.i_Rx_Serial = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx_if.i_Rx_Serial = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checks++;
        if (active_seen - a0 !== CPB / 2) $display("FAIL glitch_start_only: active %0d want %0d", active_seen - a0, CPB / 2);
        else passed++;
        checks++;
        if ({rx_if.o_Rx_Active, rx_if.o_Rx_DV} !== 2'b00 || (perr_seen - p0) + (ferr_seen - f0) + (ovr_seen - o0) != 0)
            $display("FAIL glitch_quiet: got act=%b dv=%b pulses=%0d want 0", rx_if.o_Rx_Active, rx_if.o_Rx_DV,
                     (perr_seen - p0) + (ferr_seen - f0) + (ovr_seen - o0));
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int code;
        logic [9:0] bits;
        send_frame(8'h77, 1'b0, 1'b1, 1'b0, 0);
        code = model_frame(8'h77, 1'b0, 1'b1, 1'b0);
        bits = {1'b1, 8'h96, 1'b0};
        for (int cyc = 0; cyc < 5 * CPB; cyc++) begin
            @(negedge clk);
            rx_if.i_Rx_Serial = bits[cyc / CPB];
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rx_if.o_Rx_DV, rx_if.o_Rx_Active, rx_if.o_Rx_Byte} !== 10'h0)
            $display("FAIL midreset_async: got dv=%b act=%b byte=%h want 0 (code %0d)", rx_if.o_Rx_DV, rx_if.o_Rx_Active, rx_if.o_Rx_Byte, code);
        else passed++;
        rx_if.i_Rx_Serial = 1'b1;
        model_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if ({rx_if.o_Rx_DV, rx_if.o_Rx_Full, rx_if.o_Rx_Active, rx_if.o_Rx_Byte} !== 11'h0)
            $display("FAIL midreset_after: got dv=%b full=%b act=%b byte=%h want 0", rx_if.o_Rx_DV, rx_if.o_Rx_Full, rx_if.o_Rx_Active, rx_if.o_Rx_Byte);
        else passed++;
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 0);
        code = model_frame(8'hC3, 1'b0, 1'b1, 1'b0);
        test_drain("midreset_next");
    endtask

    task automatic test_random();
        int p0, f0, o0, a0, code;
        logic [7:0] d;
        bit pb, sb, rd;
        for (int i = 0; i < 16; i++) begin
            d  = 8'($urandom);
            pb = PAR_EN && ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 5) != 0);
            rd = ($urandom_range(0, 2) == 0);
            p0 = perr_seen; f0 = ferr_seen; o0 = ovr_seen; a0 = active_seen;
            send_frame(d, pb, sb, rd, 0);
            code = model_frame(d, pb, sb, rd);
            checks++;
            if ({perr_seen - p0, ferr_seen - f0, ovr_seen - o0} !== {((code == 2) ? 1 : 0), ((code == 1) ? 1 : 0), ((code == 3) ? 1 : 0)})
                $display("FAIL rand_pulses_%0d: got pe=%0d fe=%0d ov=%0d want outcome %0d", i, perr_seen - p0, ferr_seen - f0, ovr_seen - o0, code);
            else passed++;
            checks++;
            if ({rx_if.o_Rx_DV, rx_if.o_Rx_Full} !== {model_q.size() > 0, model_q.size() == DEPTH})
                $display("FAIL rand_flags_%0d: got dv=%b full=%b want size %0d", i, rx_if.o_Rx_DV, rx_if.o_Rx_Full, model_q.size());
            else passed++;
            checks++;
            if (active_seen - a0 !== ACTIVE_CYC) $display("FAIL rand_active_%0d: got %0d want %0d", i, active_seen - a0, ACTIVE_CYC);
            else passed++;
            if (model_q.size() > 0) begin
                checks++;
                if (rx_if.o_Rx_Byte !== model_q[0]) $display("FAIL rand_head_%0d: got %h want %h", i, rx_if.o_Rx_Byte, model_q[0]);
                else passed++;
            end
            if ($urandom_range(0, 3) == 0) test_drain("rand");
        end
        test_drain("rand_end");
    endtask

    initial begin
        rx_if.i_Rx_Serial = 1'b1;
        rx_if.i_Rx_Read   = 1'b0;
        rst_n = 1'b0;
        dv_b  = 1'b0;
        dv_a  = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

endmodule
